// File: rtl/eth_fcs_rx_strip_if.sv
// Byte-wide AXI-Stream channel for the RX FCS stripper.
// ETH_FCS_RX_TUSER_EN adds a tuser bit driven by the master side.
interface eth_fcs_rx_strip_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
`ifdef ETH_FCS_RX_TUSER_EN
    logic       tuser;
`endif

    modport master (
        input  tready,
        output tdata,
        output tvalid,
`ifdef ETH_FCS_RX_TUSER_EN
        output tuser,
`endif
        output tlast
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/eth_fcs_rx_strip.sv
// RX Ethernet FCS check and strip: CRC-32 over whole frame, 4-byte hold delay.
// Optional ETH_FCS_RX_TUSER_EN flags bad/oversize frames on the tlast beat.
module eth_fcs_rx_strip #(
    parameter logic [31:0] CRC_INIT    = 32'hFFFFFFFF,
    parameter logic [31:0] CRC_RESIDUE = 32'hDEBB20E3,
    parameter int          MAX_LEN     = 1522,
    parameter int          LEN_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    eth_fcs_rx_strip_if.slave  s_axis,
    eth_fcs_rx_strip_if.master m_axis,
    output logic               bad_fcs,
    output logic               runt,
    output logic [LEN_W-1:0]   frame_len
);

    localparam logic [LEN_W-1:0] LEN_SAT  = '1;
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] RUNT_LEN = LEN_W'(4);
    localparam logic [LEN_W-1:0] OVER_LEN = LEN_W'(MAX_LEN);

    function automatic logic [31:0] crc_step(input logic [31:0] c,
                                             input logic [7:0]  d);
        logic [31:0] x;
        x = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
        end
        return x;
    endfunction

    logic [3:0][7:0]  hold_q, hold_d;
    logic [2:0]       fill_q, fill_d;
    logic [31:0]      crc_q, crc_d, crc_nxt;
    logic [LEN_W-1:0] len_q, len_d, len_nxt;
    logic [7:0]       tdata_q, tdata_d;
    logic             tvalid_q, tvalid_d;
    logic             tlast_q, tlast_d;
    logic             bad_q, bad_d;
    logic             runt_q, runt_d;
    logic [LEN_W-1:0] flen_q, flen_d;
`ifdef ETH_FCS_RX_TUSER_EN
    logic             tuser_q, tuser_d;
`endif

    logic accept;
    logic full;
    logic eof;
    logic fcs_err;
    logic is_runt;
    logic is_over;

    assign s_axis.tready = !tvalid_q || m_axis.tready;
    assign accept        = s_axis.tvalid && s_axis.tready;
    assign full          = (fill_q == 3'd4);
    assign eof           = accept && s_axis.tlast;

    assign crc_nxt = crc_step(crc_q, s_axis.tdata);
    assign len_nxt = (len_q == LEN_SAT) ? len_q : len_q + LEN_ONE;
    assign fcs_err = (crc_nxt != CRC_RESIDUE);
    assign is_runt = (len_nxt <= RUNT_LEN);
    assign is_over = (len_nxt > OVER_LEN);

    // Hold buffer: slot 0 is the oldest byte, new bytes enter at the top.
    always_comb begin
        hold_d = hold_q;
        fill_d = fill_q;
        crc_d  = crc_q;
        len_d  = len_q;
        if (accept) begin
            if (full) begin
                hold_d = {s_axis.tdata, hold_q[3], hold_q[2], hold_q[1]};
            end else begin
                hold_d[fill_q[1:0]] = s_axis.tdata;
                fill_d              = fill_q + 3'd1;
            end
            if (s_axis.tlast) begin
                fill_d = 3'd0;
                crc_d  = CRC_INIT;
                len_d  = '0;
            end else begin
                crc_d  = crc_nxt;
                len_d  = len_nxt;
            end
        end
    end

    always_comb begin
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
`ifdef ETH_FCS_RX_TUSER_EN
        tuser_d  = tuser_q;
`endif
        if (accept && full) begin
            tvalid_d = 1'b1;
            tdata_d  = hold_q[0];
            tlast_d  = s_axis.tlast;
`ifdef ETH_FCS_RX_TUSER_EN
            tuser_d  = s_axis.tlast && (fcs_err || is_over);
`endif
        end else if (m_axis.tready) begin
            tvalid_d = 1'b0;
        end
    end

    always_comb begin
        bad_d  = eof && (fcs_err || is_runt || is_over);
        runt_d = eof && is_runt;
        flen_d = eof ? len_nxt : flen_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q   <= '0;
            fill_q   <= 3'd0;
            crc_q    <= CRC_INIT;
            len_q    <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= 8'h00;
            tlast_q  <= 1'b0;
            bad_q    <= 1'b0;
            runt_q   <= 1'b0;
            flen_q   <= '0;
        end else begin
            hold_q   <= hold_d;
            fill_q   <= fill_d;
            crc_q    <= crc_d;
            len_q    <= len_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
            bad_q    <= bad_d;
            runt_q   <= runt_d;
            flen_q   <= flen_d;
        end
    end

`ifdef ETH_FCS_RX_TUSER_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tuser_q <= 1'b0;
        end else begin
            tuser_q <= tuser_d;
        end
    end

    assign m_axis.tuser = tuser_q;
`endif

    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tlast  = tlast_q;
    assign bad_fcs       = bad_q;
    assign runt          = runt_q;
    assign frame_len     = flen_q;

endmodule

// File: tb/tb_eth_fcs_rx_strip.sv
// Directed bench for eth_fcs_rx_strip: frame table plus corner sequences.
// Covers good/bad FCS, runts, backpressure, length limits and reset.
module tb_eth_fcs_rx_strip;

    typedef byte unsigned byte_q_t[$];

    typedef struct {
        byte unsigned d[16];
        int           n;
        int           mode;
        bit           gap;
        int           ebeats;
        int           ebad;
        int           erunt;
        int           elen;
        bit           etuser;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bad_fcs;
    logic        runt;
    logic [15:0] frame_len;

    eth_fcs_rx_strip_if s_if();
    eth_fcs_rx_strip_if m_if();

    eth_fcs_rx_strip dut (
        .clk       (clk),
        .rst       (rst),
        .s_axis    (s_if),
        .m_axis    (m_if),
        .bad_fcs   (bad_fcs),
        .runt      (runt),
        .frame_len (frame_len)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string nm, input longint act,
                            input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge
    byte unsigned ob[$];
    bit           ol[$];
    bit           ou[$];
    int           nbad;
    int           nrunt;

    initial begin
        logic [7:0] pd;
        logic       pl;
        bit         pstall;
        pd     = 8'h00;
        pl     = 1'b0;
        pstall = 1'b0;
        nbad   = 0;
        nrunt  = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pstall = 1'b0;
            end else begin
                check_eq("s_tready", s_if.tready,
                         !m_if.tvalid || m_if.tready);
                if (pstall) begin
                    check_eq("stall_valid", m_if.tvalid, 1);
                    check_eq("stall_data", m_if.tdata, pd);
                    check_eq("stall_last", m_if.tlast, pl);
                end
                pstall = m_if.tvalid && !m_if.tready;
                pd     = m_if.tdata;
                pl     = m_if.tlast;
                if (m_if.tvalid && m_if.tready) begin
                    ob.push_back(m_if.tdata);
                    ol.push_back(m_if.tlast);
`ifdef ETH_FCS_RX_TUSER_EN
                    ou.push_back(m_if.tuser);
`else
                    ou.push_back(1'b0);
`endif
                end
                if (bad_fcs) nbad++;
                if (runt) nrunt++;
            end
        end
    end

    // Downstream ready: 0 = always, 1 = pattern 1,0,0,1, 2 = never
    int rdy_mode = 0;
    int rdy_idx  = 0;

    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: m_if.tready = 1'b1;
                1: begin
                    m_if.tready = (rdy_idx % 4 == 0) || (rdy_idx % 4 == 3);
                    rdy_idx++;
                end
                default: m_if.tready = 1'b0;
            endcase
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    task automatic clr();
        ob.delete();
        ol.delete();
        ou.delete();
        nbad  = 0;
        nrunt = 0;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit last);
        int t;
        s_if.tdata  = d;
        s_if.tvalid = 1'b1;
        s_if.tlast  = last;
        t = 0;
        @(negedge clk);
        while (!s_if.tready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: waited %0d cycles limit 200", t);
        end
        @(posedge clk);
        #1;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic send_frame(input byte_q_t f, input bit gap);
        for (int i = 0; i < f.size(); i++) begin
            send_byte(f[i], i == f.size() - 1);
            if (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic check_out(input string nm, input byte_q_t ed,
                             input int la, input int lb, input bit etu,
                             input int ebad, input int erunt,
                             input int elen);
        bit el;
        repeat (8) @(posedge clk);
        #1;
        check_eq({nm, "_beats"}, ob.size(), ed.size());
        for (int i = 0; i < ed.size() && i < ob.size(); i++) begin
            el = (i == la) || (i == lb);
            check_eq($sformatf("%s_data%0d", nm, i), ob[i], ed[i]);
            check_eq($sformatf("%s_last%0d", nm, i), ol[i], el);
`ifdef ETH_FCS_RX_TUSER_EN
            check_eq($sformatf("%s_tuser%0d", nm, i), ou[i], el && etu);
`endif
        end
        check_eq({nm, "_bad_cycles"}, nbad, ebad);
        check_eq({nm, "_runt_cycles"}, nrunt, erunt);
        check_eq({nm, "_frame_len"}, frame_len, elen);
    endtask

    function automatic byte_q_t with_fcs(input byte_q_t p);
        logic [31:0] c;
        byte_q_t     r;
        c = 32'hFFFFFFFF;
        r = p;
        for (int i = 0; i < p.size(); i++) begin
            c = c ^ {24'h0, p[i]};
            for (int b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        c = ~c;
        for (int i = 0; i < 4; i++) r.push_back(c[8*i +: 8]);
        return r;
    endfunction

    vec_t vt[7];

    task automatic add_vec(input int k, input byte_q_t b, input int mode,
                           input bit gap, input int ebeats, input int ebad,
                           input int erunt, input int elen, input bit etu);
        vt[k].n = b.size();
        for (int i = 0; i < 16; i++) vt[k].d[i] = (i < b.size()) ? b[i] : 8'h00;
        vt[k].mode   = mode;
        vt[k].gap    = gap;
        vt[k].ebeats = ebeats;
        vt[k].ebad   = ebad;
        vt[k].erunt  = erunt;
        vt[k].elen   = elen;
        vt[k].etuser = etu;
    endtask

    initial begin
        byte_q_t f;
        byte_q_t f2;
        byte_q_t ed;

        s_if.tdata  = 8'h00;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
`ifdef ETH_FCS_RX_TUSER_EN
        s_if.tuser  = 1'b0;
`endif

        add_vec(0, {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38,
                    8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB}, 0, 0, 9, 0, 0, 13, 0);
        add_vec(1, {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38,
                    8'h39, 8'h26, 8'h39, 8'hF4, 8'hCA}, 0, 0, 9, 1, 0, 13, 1);
        add_vec(2, {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38,
                    8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB}, 1, 0, 9, 0, 0, 13, 0);
        add_vec(3, {8'hAA, 8'hBB, 8'hCC}, 0, 0, 0, 1, 1, 3, 0);
        add_vec(4, {8'h01, 8'h02, 8'h03, 8'h04}, 0, 0, 0, 1, 1, 4, 0);
        add_vec(5, {8'h11, 8'h22, 8'h33, 8'h44, 8'h55}, 0, 0, 1, 1, 0, 5, 1);
        add_vec(6, {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38,
                    8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB}, 1, 1, 9, 0, 0, 13, 0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_m_tvalid", m_if.tvalid, 0);
        check_eq("rst_m_tlast", m_if.tlast, 0);
        check_eq("rst_m_tdata", m_if.tdata, 0);
        check_eq("rst_bad_fcs", bad_fcs, 0);
        check_eq("rst_runt", runt, 0);
        check_eq("rst_frame_len", frame_len, 0);
        check_eq("rst_s_tready", s_if.tready, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int k = 0; k < 7; k++) begin
            f = {};
            for (int i = 0; i < vt[k].n; i++) f.push_back(vt[k].d[i]);
            ed = {};
            for (int i = 0; i < vt[k].ebeats; i++) ed.push_back(vt[k].d[i]);
            rdy_mode = vt[k].mode;
            rdy_idx  = 0;
            clr();
            send_frame(f, vt[k].gap);
            check_out($sformatf("vec%0d", k), ed, vt[k].ebeats - 1, -1,
                      vt[k].etuser, vt[k].ebad, vt[k].erunt, vt[k].elen);
            rdy_mode = 0;
        end

        // Back-to-back good frames
        f = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38,
             8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
        f2 = f;
        for (int i = 0; i < 4; i++) void'(f2.pop_back());
        ed = {f2, f2};
        clr();
        send_frame(f, 0);
        send_frame(f, 0);
        check_out("b2b", ed, 8, 17, 0, 0, 0, 13);

        // Length limit: 1522 total is legal, 1523 is oversize
        f2 = {};
        for (int i = 0; i < 1518; i++) f2.push_back(8'((i * 7 + 3) & 255));
        f = with_fcs(f2);
        clr();
        send_frame(f, 0);
        check_out("len1522", f2, 1517, -1, 0, 0, 0, 1522);
        f2.push_back(8'h5A);
        f = with_fcs(f2);
        clr();
        send_frame(f, 0);
        check_out("len1523", f2, 1518, -1, 1, 1, 0, 1523);

        // Reset mid-frame with a byte held in the output register
        rdy_mode = 2;
        @(posedge clk);
        #2;
        clr();
        for (int i = 0; i < 5; i++) send_byte(8'(8'h41 + i), 1'b0);
        s_if.tdata  = 8'h46;
        s_if.tvalid = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midrst_s_tready", s_if.tready, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        s_if.tvalid = 1'b0;
        check_eq("midrst_flush_valid", m_if.tvalid, 0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        rdy_mode = 0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("midrst_beats", ob.size(), 0);
        check_eq("midrst_bad", nbad, 0);
        check_eq("midrst_frame_len", frame_len, 0);
        f = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38,
             8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
        ed = f;
        for (int i = 0; i < 4; i++) void'(ed.pop_back());
        clr();
        send_frame(f, 0);
        check_out("postrst", ed, 8, -1, 0, 0, 0, 13);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
